// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - WIDTH-bit J-K register bank with JK/D/T/SHIFT modes and per-bit set/clear masks
// Optional master-slave stage: define JK_REG_MS_STAGE_EN for 2-edge input-to-Q latency.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             SIn,
  input  logic [WIDTH-1:0] SetV,
  input  logic [WIDTH-1:0] ClrV,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             SOut,
  output logic             Chg
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_D     = 2'b01,
    MODE_T     = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] func_d;
  logic [WIDTH-1:0] next_d;
  logic             chg_q;

  always_comb begin
    func_d = q_q;
    case (mode_e'(Mode))
      MODE_JK:    func_d = (J & ~q_q) | (~K & q_q);
      MODE_D:     func_d = J;
      MODE_T:     func_d = q_q ^ J;
      MODE_SHIFT: func_d = {q_q[WIDTH-2:0], SIn};
      default:    func_d = q_q;
    endcase
  end

  // Masks act even while En=0; clear beats set on the same bit.
  always_comb begin
    next_d = En ? func_d : q_q;
    next_d = (next_d | SetV) & ~ClrV;
  end

`ifdef JK_REG_MS_STAGE_EN
  logic [WIDTH-1:0] master_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      master_q <= RESET_VAL;
      q_q      <= RESET_VAL;
      chg_q    <= 1'b0;
    end else begin
      master_q <= next_d;
      q_q      <= master_q;
      chg_q    <= (master_q != q_q);
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q   <= RESET_VAL;
      chg_q <= 1'b0;
    end else begin
      q_q   <= next_d;
      chg_q <= (next_d != q_q);
    end
  end
`endif

  assign Q    = q_q;
  assign Qb   = ~q_q;
  assign SOut = q_q[WIDTH-1];
  assign Chg  = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - directed self-checking bench for jk_reg_bank (WIDTH=8)
// Covers the single-stage build, or the JK_REG_MS_STAGE_EN build when that macro is defined.
module tb_jk_reg_bank;

  localparam int W = 8;

  logic         Clk;
  logic         Rst;
  logic         En;
  logic [1:0]   Mode;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic         SIn;
  logic [W-1:0] SetV;
  logic [W-1:0] ClrV;
  logic [W-1:0] Q;
  logic [W-1:0] Qb;
  logic         SOut;
  logic         Chg;

  int n_checks = 0;
  int n_pass   = 0;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .J(J), .K(K), .SIn(SIn),
    .SetV(SetV), .ClrV(ClrV), .Q(Q), .Qb(Qb), .SOut(SOut), .Chg(Chg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_d(input logic [W-1:0] v);
    Rst = 0; En = 1; Mode = 2'b01; J = v; K = '0; SetV = '0; ClrV = '0;
    step();
  endtask

  initial begin
    Rst = 1; En = 1; Mode = 2'b01; J = 8'hFF; K = '0; SIn = 0; SetV = '0; ClrV = '0;
    #2;
    step();
    check("rst_q",   Q,   8'h00);
    check("rst_qb",  Qb,  8'hFF);
    check("rst_chg", Chg, 1'b0);

`ifdef JK_REG_MS_STAGE_EN
    Rst = 0; Mode = 2'b01; J = 8'h3C;
    step();
    check("ms_first_q",   Q,   8'h00);
    check("ms_first_chg", Chg, 1'b0);
    step();
    check("ms_second_q",   Q,   8'h3C);
    check("ms_second_chg", Chg, 1'b1);
    check("ms_second_qb",  Qb,  8'hC3);
    Rst = 1;
    step();
    check("ms_rst_q", Q, 8'h00);
    Rst = 0; J = 8'hFF;
    step();
    check("ms_cap_q", Q, 8'h00);
    Rst = 1;
    step();
    check("ms_rst_mid_q", Q, 8'h00);
    Rst = 0; J = 8'h00;
    step();
    check("ms_after1_q", Q, 8'h00);
    step();
    check("ms_after2_q",   Q,   8'h00);
    check("ms_after2_chg", Chg, 1'b0);
`else
    Rst = 0;
    step();
    check("d_ff_q",   Q,   8'hFF);
    check("d_ff_chg", Chg, 1'b1);

    load_d(8'h0F);
    check("load_0f", Q, 8'h0F);
    Mode = 2'b00; J = 8'hAA; K = 8'h66;
    step();
    check("jk_q",   Q,   8'hA9);
    check("jk_chg", Chg, 1'b1);
    J = 8'h00; K = 8'h00;
    step();
    check("jk_hold_q",   Q,   8'hA9);
    check("jk_hold_chg", Chg, 1'b0);

    load_d(8'h81);
    check("sout_pre", SOut, 1'b1);
    Mode = 2'b11; SIn = 1;
    step();
    check("sh1_q", Q, 8'h03);
    check("sh1_sout", SOut, 1'b0);
    step();
    check("sh2_q", Q, 8'h07);
    step();
    check("sh3_q", Q, 8'h0F);
    check("sh3_sout", SOut, 1'b0);

    // Masked bit 0 still feeds its pre-edge value into bit 1.
    load_d(8'h03);
    Mode = 2'b11; SIn = 1; ClrV = 8'h01;
    step();
    check("sh_mask_q", Q, 8'h06);
    ClrV = '0; Rst = 1;
    step();
    check("sh_rst_q",   Q,   8'h00);
    check("sh_rst_chg", Chg, 1'b0);

    Rst = 0; Mode = 2'b10; J = 8'hFF; ClrV = 8'h01; SetV = 8'h81;
    step();
    check("t_mask_q",  Q,  8'hFE);
    check("t_mask_qb", Qb, 8'h01);
    ClrV = '0; SetV = '0;
    step();
    check("t_wrap_q", Q, 8'h01);

    Rst = 1;
    step();
    Rst = 0; En = 0; Mode = 2'b01; J = 8'h55; SetV = 8'h10;
    step();
    check("en0_set_q",   Q,   8'h10);
    check("en0_set_chg", Chg, 1'b1);
    SetV = '0;
    step();
    check("en0_hold_q",   Q,   8'h10);
    check("en0_hold_chg", Chg, 1'b0);
    Rst = 1; SetV = 8'hFF; En = 1;
    step();
    check("rst_over_set", Q, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
